// File: rtl/quad_encoder_counter.sv
// Quadrature encoder front end: synchronise, glitch-filter and Gray-decode A/B into a
// wrapping signed position count, a one-cycle direction pulse and a sticky error flag.
module quad_encoder_counter #(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int RES         = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 A,
  input  logic                 B,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count,
  output logic [1:0]           dir,
  output logic                 err,
  output logic                 ready
);

  localparam int IW = $clog2(SYNC_STAGES + 1) + 1;
  localparam int FW = $clog2(FILT_LEN + 1);

  // Handshake: none. ready is a level (state == RUN); dir is a one-cycle pulse that is
  // valid in the cycle after the qualifying edge, with no backpressure from the consumer.

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] a_sync, b_sync;
  logic [1:0]             sync_ab;
  logic [1:0]             filt_ab;
  logic [1:0]             prev_ab;
  logic [FW-1:0]          fcnt [2];
  logic [IW-1:0]          init_cnt;
  logic                   init_done;
  logic                   in_init;
  logic                   in_run;

  logic [3:0]             trans;
  logic                   fwd_raw, rev_raw, illegal;
  logic                   qual;
  logic                   fwd_step, rev_step;

  assign sync_ab   = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};
  assign init_done = (init_cnt == IW'(SYNC_STAGES));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (init_done) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // ---------------- FSM: outputs (ready doubles as the visible state) ----------------
  always_comb begin
    in_init = 1'b0;
    in_run  = 1'b0;
    ready   = 1'b0;
    case (state)
      ST_INIT: in_init = 1'b1;
      ST_RUN: begin
        in_run = 1'b1;
        ready  = 1'b1;
      end
      default: in_init = 1'b1;
    endcase
  end

  // ---------------- INIT cycle counter ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_cnt <= '0;
    end else if (in_init && !init_done) begin
      init_cnt <= init_cnt + IW'(1);
    end
  end

  // ---------------- input synchronisers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sync <= '0;
      b_sync <= '0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], A};
      b_sync <= {b_sync[SYNC_STAGES-2:0], B};
    end
  end

  // ---------------- glitch filter and previous-state register ----------------
  // During INIT both filt_ab and prev_ab track the synced pins so RUN starts with no
  // pending transition, whatever level the encoder happens to rest at.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_ab <= '0;
      prev_ab <= '0;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else if (in_init) begin
      filt_ab <= sync_ab;
      prev_ab <= sync_ab;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      prev_ab <= filt_ab;
      for (int i = 0; i < 2; i++) begin
        if (sync_ab[i] != filt_ab[i]) begin
          if (fcnt[i] == FW'(FILT_LEN - 1)) begin
            filt_ab[i] <= sync_ab[i];
            fcnt[i]    <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + FW'(1);
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  // ---------------- Gray-code decode ----------------
  assign trans = {prev_ab, filt_ab};

  always_comb begin
    fwd_raw = 1'b0;
    rev_raw = 1'b0;
    illegal = 1'b0;
    case (trans)
      4'b0010, 4'b1011, 4'b1101, 4'b0100: fwd_raw = 1'b1;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: rev_raw = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal = 1'b1;
      default: ;
    endcase
  end

  // x1 counts only the 00<->10 edge, x2 every A edge, x4 every edge.
  always_comb begin
    qual = 1'b1;
    if (RES == 1) begin
      qual = (trans == 4'b0010) || (trans == 4'b1000);
    end else if (RES == 2) begin
      qual = prev_ab[1] ^ filt_ab[1];
    end
  end

  assign fwd_step = in_run && fwd_raw && qual;
  assign rev_step = in_run && rev_raw && qual;

  // ---------------- position, direction and error ----------------
  // clr has priority: a step landing on the same edge is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      dir   <= 2'b00;
      err   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      dir   <= 2'b00;
      err   <= 1'b0;
    end else begin
      dir <= 2'b00;
      if (in_run && illegal) begin
        err <= 1'b1;
      end else if (fwd_step) begin
        count <= count + CNT_WIDTH'(1);
        dir   <= 2'b01;
      end else if (rev_step) begin
        count <= count - CNT_WIDTH'(1);
        dir   <= 2'b10;
      end
    end
  end

endmodule
